i4004_bus_master: RTL and testbench

I4004_BUS_MASTER -- requirements
Module: i4004_bus_master

---
 rtl/mcs4_pkg.sv | 22 ++
 rtl/i4004_bus_master_if.sv | 31 +++
 rtl/i4004_phase_gen.sv | 75 +++++++
 rtl/i4004_bus_master.sv | 154 +++++++++++++++
 tb/tb_i4004_bus_master.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mcs4_pkg.sv
// Shared types for the MCS-4 bus master: subcycle order, I/O command codes and
// the OPR value that marks an I/O instruction.
package mcs4_pkg;

    typedef enum logic [2:0] {
        SubA1, SubA2, SubA3, SubM1, SubM2, SubX1, SubX2, SubX3
    } subcycle_e;

    typedef enum logic [1:0] {
        IoNone = 2'd0,
        IoSrc  = 2'd1,
        IoWrr  = 2'd2,
        IoRdr  = 2'd3
    } io_cmd_e;

    localparam logic [3:0] OPR_IO = 4'hE;

    function automatic subcycle_e next_subcycle(subcycle_e s);
        return subcycle_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/i4004_bus_master_if.sv
// Pad-side and host-side signals of the 4004 bus master, grouped for the DUT
// (master) and its environment (slave).
interface i4004_bus_master_if;
    logic        clk1_pad;
    logic        clk2_pad;
    logic        sync_pad;
    logic        cmrom_pad;
    logic [3:0]  data_pad;
    logic [3:0]  data_out;
    logic        data_dir;
    logic [11:0] pc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        instr_valid;
    logic [1:0]  io_cmd;
    logic [3:0]  io_data;
    logic [3:0]  rd_data;
    logic        rd_valid;

    modport master (
        output clk1_pad, clk2_pad, sync_pad, cmrom_pad, data_out, data_dir,
        output opr, opa, instr_valid, rd_data, rd_valid,
        input  data_pad, pc, io_cmd, io_data
    );

    modport slave (
        input  clk1_pad, clk2_pad, sync_pad, cmrom_pad, data_out, data_dir,
        input  opr, opa, instr_valid, rd_data, rd_valid,
        output data_pad, pc, io_cmd, io_data
    );
endinterface

// File: rtl/i4004_phase_gen.sv
// Divider / quarter / subcycle sequencer with registered clk1, clk2 and sync.
// Exports the current phase plus the phase of the next tick for registered outputs.
module i4004_phase_gen
    import mcs4_pkg::*;
#(
    parameter int unsigned PHASE_DIV = 1
) (
    input  logic      sysclk,
    input  logic      poc,
    output subcycle_e subcycle,
    output logic [1:0] quarter,
    output logic      tick_last,
    output subcycle_e nxt_subcycle,
    output logic [1:0] nxt_quarter,
    output logic      nxt_enter,
    output logic      nxt_last,
    output logic      clk1,
    output logic      clk2,
    output logic      sync
);

    localparam logic [3:0] DIV_LAST = 4'(PHASE_DIV - 1);

    logic       run_q;
    logic [3:0] div_q, div_d;
    logic [1:0] qtr_q, qtr_d;
    subcycle_e  sub_q, sub_d;

    // Phase is frozen until the first tick after reset so X3 Q0 is shown in full.
    always_comb begin
        div_d = div_q;
        qtr_d = qtr_q;
        sub_d = sub_q;
        if (run_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    sub_d = next_subcycle(sub_q);
                end
            end else begin
                div_d = div_q + 4'd1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            run_q <= 1'b0;
            div_q <= '0;
            qtr_q <= '0;
            sub_q <= SubX3;
            clk1  <= 1'b0;
            clk2  <= 1'b0;
            sync  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            div_q <= div_d;
            qtr_q <= qtr_d;
            sub_q <= sub_d;
            clk1  <= (qtr_d == 2'd0);
            clk2  <= (qtr_d == 2'd2);
            sync  <= (sub_d == SubX3);
        end
    end

    assign subcycle     = sub_q;
    assign quarter      = qtr_q;
    assign tick_last    = run_q && (div_q == DIV_LAST);
    assign nxt_subcycle = sub_d;
    assign nxt_quarter  = qtr_d;
    assign nxt_enter    = !run_q || tick_last;
    assign nxt_last     = (div_d == DIV_LAST);

endmodule

// File: rtl/i4004_bus_master.sv
// 4004-style bus master: address out, instruction fetch and, with MCS4_BUS_IO_EN
// defined, the SRC/WRR/RDR I/O phase in X2.
module i4004_bus_master
    import mcs4_pkg::*;
#(
    parameter int unsigned PHASE_DIV = 1
) (
    input  logic sysclk,
    input  logic poc,
    i4004_bus_master_if.master bus
);

    subcycle_e  sub, nxt_sub;
    logic [1:0] qtr, nxt_qtr;
    logic       tick_last, nxt_enter, nxt_last;
    logic       clk1, clk2, sync;

    i4004_phase_gen #(.PHASE_DIV(PHASE_DIV)) u_phase (
        .sysclk      (sysclk),
        .poc         (poc),
        .subcycle    (sub),
        .quarter     (qtr),
        .tick_last   (tick_last),
        .nxt_subcycle(nxt_sub),
        .nxt_quarter (nxt_qtr),
        .nxt_enter   (nxt_enter),
        .nxt_last    (nxt_last),
        .clk1        (clk1),
        .clk2        (clk2),
        .sync        (sync)
    );

    logic [11:0] pc_q, pc_s;
    logic [3:0]  opr_q, opa_q, dout_q, dout_d;
    logic        dir_q, dir_d, cm_q, cm_d, iv_q, iv_d;
    logic        enter_a1, cap_opr, cap_opa;

    // pc is only taken on the tick that enters A1 Q0.
    assign enter_a1 = nxt_enter && (nxt_sub == SubA1) && (nxt_qtr == 2'd0);
    assign pc_s     = enter_a1 ? bus.pc : pc_q;
    assign cap_opr  = tick_last && (sub == SubM1) && (qtr == 2'd2);
    assign cap_opa  = tick_last && (sub == SubM2) && (qtr == 2'd2);
    assign iv_d     = nxt_last && (nxt_sub == SubM2) && (nxt_qtr == 2'd3);

`ifdef MCS4_BUS_IO_EN
    io_cmd_e    cmd_q, cmd_s;
    logic [3:0] io_q, io_s, rd_q;
    logic       rv_q, enter_x1, cap_rd;

    assign enter_x1 = nxt_enter && (nxt_sub == SubX1) && (nxt_qtr == 2'd0);
    assign cmd_s    = enter_x1 ? io_cmd_e'(bus.io_cmd) : cmd_q;
    assign io_s     = enter_x1 ? bus.io_data : io_q;
    assign cap_rd   = tick_last && (sub == SubX2) && (qtr == 2'd2) && (cmd_q == IoRdr);

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            cmd_q <= IoNone;
            io_q  <= '0;
            rd_q  <= '0;
            rv_q  <= 1'b0;
        end else begin
            cmd_q <= cmd_s;
            io_q  <= io_s;
            rv_q  <= cap_rd;
            if (cap_rd) begin
                rd_q <= bus.data_pad;
            end
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rv_q;
`else
    logic unused_io;
    assign unused_io    = ^{bus.io_cmd, bus.io_data};
    assign bus.rd_data  = '0;
    assign bus.rd_valid = 1'b0;
`endif

    // Bus drive for the tick about to start; released bus always reads as zero.
    always_comb begin
        dout_d = '0;
        dir_d  = 1'b0;
        cm_d   = 1'b0;
        case (nxt_sub)
            SubA1: begin
                dout_d = pc_s[3:0];
                dir_d  = 1'b1;
            end
            SubA2: begin
                dout_d = pc_s[7:4];
                dir_d  = 1'b1;
            end
            SubA3: begin
                dout_d = pc_s[11:8];
                dir_d  = 1'b1;
                cm_d   = 1'b1;
            end
`ifdef MCS4_BUS_IO_EN
            SubM2: cm_d = (opr_q == OPR_IO);
            SubX2: begin
                case (cmd_s)
                    IoSrc: begin
                        dout_d = io_s;
                        dir_d  = 1'b1;
                        cm_d   = 1'b1;
                    end
                    IoWrr: begin
                        dout_d = io_s;
                        dir_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            pc_q   <= '0;
            opr_q  <= '0;
            opa_q  <= '0;
            dout_q <= '0;
            dir_q  <= 1'b0;
            cm_q   <= 1'b0;
            iv_q   <= 1'b0;
        end else begin
            pc_q   <= pc_s;
            dout_q <= dout_d;
            dir_q  <= dir_d;
            cm_q   <= cm_d;
            iv_q   <= iv_d;
            if (cap_opr) begin
                opr_q <= bus.data_pad;
            end
            if (cap_opa) begin
                opa_q <= bus.data_pad;
            end
        end
    end

    assign bus.clk1_pad    = clk1;
    assign bus.clk2_pad    = clk2;
    assign bus.sync_pad    = sync;
    assign bus.cmrom_pad   = cm_q;
    assign bus.data_out    = dout_q;
    assign bus.data_dir    = dir_q;
    assign bus.opr         = opr_q;
    assign bus.opa         = opa_q;
    assign bus.instr_valid = iv_q;

endmodule

// File: tb/tb_i4004_bus_master.sv
// Bench for i4004_bus_master: directed cycle table, randomised cycles against a
// tick-position model, and a mid-M1 poc abort. Honours MCS4_BUS_IO_EN.
module tb_i4004_bus_master;
    import mcs4_pkg::*;

    localparam int unsigned PD  = 1;
    localparam int          TPC = 32 * PD;
`ifdef MCS4_BUS_IO_EN
    localparam bit IO = 1'b1;
`else
    localparam bit IO = 1'b0;
`endif

    typedef struct {
        logic [11:0] pc;
        logic [3:0]  opr_in;
        logic [3:0]  opa_in;
        logic [1:0]  cmd;
        logic [3:0]  io_data;
        logic [3:0]  rd_in;
    } cyc_t;

    typedef struct {
        logic [3:0] opr;
        logic [3:0] opa;
        logic [3:0] x2_out;
        logic [3:0] rd;
        logic       cm_m2;
        logic       x2_dir;
        logic       cm_x2;
        int         iv_cnt;
        int         rv_cnt;
    } obs_t;

    typedef struct {
        cyc_t stim;
        obs_t exp;
    } vec_t;

    logic sysclk = 1'b0;
    logic poc    = 1'b1;
    i4004_bus_master_if bus ();

    i4004_bus_master #(.PHASE_DIV(PD)) dut (
        .sysclk(sysclk),
        .poc   (poc),
        .bus   (bus)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: values latched at the bus sample points.
    logic [11:0] m_pc;
    logic [3:0]  m_opr, m_opa, m_rd, m_io;
    logic [1:0]  m_cmd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [22:0] pack_out();
        return {bus.clk1_pad, bus.clk2_pad, bus.sync_pad, bus.cmrom_pad, bus.data_dir,
                bus.data_out, bus.opr, bus.opa, bus.instr_valid, bus.rd_data, bus.rd_valid};
    endfunction

    // Cycle position s: 0=X3 (first after reset), 1..3=A1..A3, 4..5=M1..M2, 6..7=X1..X2.
    function automatic int tick_of(int s, int q);
        return (s * 4 + q) * PD + PD - 1;
    endfunction

    function automatic logic [22:0] model(int p);
        int s = p / (4 * PD);
        int q = (p / PD) % 4;
        bit first = (p % PD) == 0;
        bit last  = (p % PD) == PD - 1;
        logic cm = 1'b0, dir = 1'b0, iv, rv = 1'b0;
        logic [3:0] out = 4'h0;
        if (s >= 1 && s <= 3) begin
            dir = 1'b1;
            out = (s == 1) ? m_pc[3:0] : (s == 2) ? m_pc[7:4] : m_pc[11:8];
        end
        if (s == 3) cm = 1'b1;
        if (IO) begin
            if (s == 5 && m_opr == 4'hE) cm = 1'b1;
            if (s == 7 && m_cmd == 2'd1) begin cm = 1'b1; dir = 1'b1; out = m_io; end
            if (s == 7 && m_cmd == 2'd2) begin dir = 1'b1; out = m_io; end
            if (s == 7 && m_cmd == 2'd3 && q == 3 && first) rv = 1'b1;
        end
        iv = (s == 5 && q == 3 && last);
        return {q == 0, q == 2, s == 0, cm, dir, out, m_opr, m_opa, iv,
                IO ? m_rd : 4'h0, rv};
    endfunction

    task automatic run_cycle(input cyc_t c, input int abort_at, output obs_t o);
        o = '{default: '0};
        for (int p = 0; p < TPC; p++) begin
            @(posedge sysclk);
            #1;
            check($sformatf("tick%0d", p), 32'(pack_out()), 32'(model(p)));
            if (p == tick_of(5, 1)) o.cm_m2 = bus.cmrom_pad;
            if (p == tick_of(7, 1)) begin
                o.x2_out = bus.data_out;
                o.x2_dir = bus.data_dir;
                o.cm_x2  = bus.cmrom_pad;
            end
            o.iv_cnt += int'(bus.instr_valid);
            o.rv_cnt += int'(bus.rd_valid);
            if (p == TPC - 1) begin
                o.opr = bus.opr;
                o.opa = bus.opa;
                o.rd  = bus.rd_data;
            end
            if (p == abort_at) begin
                poc = 1'b1;
                #1;
                check("abort_now", 32'(pack_out()), 32'h0);
                repeat (3) begin
                    @(posedge sysclk);
                    #1;
                    check("abort_hold", 32'(pack_out()), 32'h0);
                end
                @(negedge sysclk);
                poc   = 1'b0;
                m_opr = 4'h0;
                m_opa = 4'h0;
                m_rd  = 4'h0;
                m_cmd = 2'd0;
                return;
            end
            // Inputs for this tick: real values only at sample points, noise elsewhere.
            bus.pc       = (p == tick_of(0, 3)) ? c.pc : 12'($urandom);
            bus.io_cmd   = (p == tick_of(5, 3)) ? c.cmd : 2'($urandom);
            bus.io_data  = (p == tick_of(5, 3)) ? c.io_data : 4'($urandom);
            bus.data_pad = 4'($urandom);
            if (p == tick_of(0, 3)) m_pc = c.pc;
            if (p == tick_of(5, 3)) begin m_cmd = c.cmd; m_io = c.io_data; end
            if (p == tick_of(4, 2)) begin bus.data_pad = c.opr_in; m_opr = c.opr_in; end
            if (p == tick_of(5, 2)) begin bus.data_pad = c.opa_in; m_opa = c.opa_in; end
            if (p == tick_of(7, 2)) begin
                bus.data_pad = c.rd_in;
                if (IO && m_cmd == 2'd3) m_rd = c.rd_in;
            end
        end
    endtask

    initial begin
        vec_t vt[4];
        obs_t o;
        cyc_t c;
        vt[0] = '{'{12'hABC, 4'hD, 4'h4, 2'd0, 4'h0, 4'h0},
                  '{4'hD, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1, 0}};
        vt[1] = '{'{12'h123, 4'hE, 4'h7, 2'd2, 4'h9, 4'h0},
                  '{4'hE, 4'h7, IO ? 4'h9 : 4'h0, 4'h0, IO, IO, 1'b0, 1, 0}};
        vt[2] = '{'{12'h456, 4'h3, 4'h1, 2'd3, 4'hF, 4'h6},
                  '{4'h3, 4'h1, 4'h0, IO ? 4'h6 : 4'h0, 1'b0, 1'b0, 1'b0, 1, IO ? 1 : 0}};
        vt[3] = '{'{12'hFED, 4'h1, 4'h2, 2'd1, 4'h5, 4'hA},
                  '{4'h1, 4'h2, IO ? 4'h5 : 4'h0, IO ? 4'h6 : 4'h0, 1'b0, IO, IO, 1, 0}};

        bus.pc = '0; bus.data_pad = '0; bus.io_cmd = '0; bus.io_data = '0;
        m_pc = '0; m_opr = '0; m_opa = '0; m_rd = '0; m_io = '0; m_cmd = '0;

        repeat (3) @(posedge sysclk);
        #1;
        check("reset", 32'(pack_out()), 32'h0);
        @(negedge sysclk);
        poc = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_cycle(vt[i].stim, -1, o);
            check($sformatf("v%0d_opr", i), 32'(o.opr), 32'(vt[i].exp.opr));
            check($sformatf("v%0d_opa", i), 32'(o.opa), 32'(vt[i].exp.opa));
            check($sformatf("v%0d_cm_m2", i), 32'(o.cm_m2), 32'(vt[i].exp.cm_m2));
            check($sformatf("v%0d_x2_out", i), 32'(o.x2_out), 32'(vt[i].exp.x2_out));
            check($sformatf("v%0d_x2_dir", i), 32'(o.x2_dir), 32'(vt[i].exp.x2_dir));
            check($sformatf("v%0d_cm_x2", i), 32'(o.cm_x2), 32'(vt[i].exp.cm_x2));
            check($sformatf("v%0d_rd", i), 32'(o.rd), 32'(vt[i].exp.rd));
            check($sformatf("v%0d_iv_cnt", i), o.iv_cnt, vt[i].exp.iv_cnt);
            check($sformatf("v%0d_rv_cnt", i), o.rv_cnt, vt[i].exp.rv_cnt);
        end

        // poc in the middle of M1, then the restart must begin with a full X3.
        c = '{12'h5A5, 4'hE, 4'h3, 2'd3, 4'h2, 4'h7};
        run_cycle(c, tick_of(4, 1) - PD + 1, o);
        run_cycle(vt[0].stim, -1, o);

        for (int i = 0; i < 12; i++) begin
            c.pc      = 12'($urandom);
            c.opr_in  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
            c.opa_in  = 4'($urandom);
            c.cmd     = 2'($urandom);
            c.io_data = 4'($urandom);
            c.rd_in   = 4'($urandom);
            run_cycle(c, -1, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
